// File: rtl/req_arbiter4.sv
// ============================================================================
// Module   : req_arbiter4
// Brief    : Four-requester arbiter with fixed or round-robin priority and
//            bounded grant tenure; registered one-hot and binary grant outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module req_arbiter4 #(
  parameter int MAX_HOLD = 8,
  parameter int CW       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       rr_mode,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid
);

  localparam logic [0:0]    S_IDLE      = 1'b0;
  localparam logic [0:0]    S_GRANT     = 1'b1;
  localparam logic [CW-1:0] c_hold_last = CW'(MAX_HOLD - 1);
  localparam logic [CW-1:0] c_hold_one  = CW'(1);

  logic [0:0]    r_state;
  logic [CW-1:0] r_hold_cnt;
  logic [1:0]    r_last_id;
  logic [3:0]    r_gnt;
  logic [1:0]    r_gnt_id;
  logic          r_gnt_valid;

  logic [0:0]    w_nxt_state;
  logic [CW-1:0] w_nxt_hold;
  logic [1:0]    w_nxt_last;
  logic [3:0]    w_nxt_gnt;
  logic [1:0]    w_nxt_id;
  logic          w_nxt_valid;

  logic [2:0]    w_arb_all;
  logic [2:0]    w_arb_excl;
  logic          w_any_req;

  function automatic logic [3:0] onehot(input logic [1:0] id);
    onehot     = 4'b0000;
    onehot[id] = 1'b1;
  endfunction

  // Returns {found, winner}; round-robin starts one past the last winner.
  function automatic logic [2:0] arb(input logic [3:0] r, input logic rr,
                                     input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    if (rr) begin
      for (int i = 4; i >= 1; i--) begin
        idx = last + 2'(i);
        if (r[idx]) res = {1'b1, idx};
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r[i]) res = {1'b1, 2'(i)};
      end
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_hold_cnt  <= '0;
      r_last_id   <= 2'b11;
      r_gnt       <= 4'b0000;
      r_gnt_id    <= 2'b00;
      r_gnt_valid <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_hold_cnt  <= w_nxt_hold;
      r_last_id   <= w_nxt_last;
      r_gnt       <= w_nxt_gnt;
      r_gnt_id    <= w_nxt_id;
      r_gnt_valid <= w_nxt_valid;
    end
  end

  always_comb begin
    w_any_req   = |req;
    w_arb_all   = arb(req, rr_mode, r_last_id);
    w_arb_excl  = arb(req & ~onehot(r_gnt_id), rr_mode, r_last_id);
    w_nxt_state = r_state;
    w_nxt_hold  = r_hold_cnt;
    w_nxt_last  = r_last_id;
    w_nxt_id    = r_gnt_id;
    w_nxt_valid = r_gnt_valid;

    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_nxt_state = S_GRANT;
          w_nxt_id    = w_arb_all[1:0];
          w_nxt_valid = 1'b1;
          w_nxt_hold  = '0;
          w_nxt_last  = w_arb_all[1:0];
        end
      end
      S_GRANT: begin
        if (!req[r_gnt_id]) begin
          if (w_any_req) begin
            w_nxt_id   = w_arb_all[1:0];
            w_nxt_hold = '0;
            w_nxt_last = w_arb_all[1:0];
          end else begin
            w_nxt_state = S_IDLE;
            w_nxt_id    = 2'b00;
            w_nxt_valid = 1'b0;
          end
        end else if (r_hold_cnt < c_hold_last) begin
          w_nxt_hold = r_hold_cnt + c_hold_one;
        end else if (w_arb_excl[2]) begin
          // Tenure spent with others waiting: hand over, excluding the holder.
          w_nxt_id   = w_arb_excl[1:0];
          w_nxt_hold = '0;
          w_nxt_last = w_arb_excl[1:0];
        end else begin
          w_nxt_hold = '0;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_id    = 2'b00;
        w_nxt_valid = 1'b0;
        w_nxt_hold  = '0;
      end
    endcase

    w_nxt_gnt = w_nxt_valid ? onehot(w_nxt_id) : 4'b0000;
  end

  always_comb begin
    gnt       = r_gnt;
    gnt_id    = r_gnt_id;
    gnt_valid = r_gnt_valid;
  end

endmodule

`default_nettype wire
